pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Parametrised pipeline hazard, forwarding and halt controller for the processor core. Tracks the destination register, write, load and halt attributes of every in-flight instruction across STAGES pipeline stages behind decode. Generates operand forwarding selects, load-use stalls, flush squashing, a sticky system halt and a stall-cycle counter. Replaces the fixed two-hazard, three-stage stall/halt logic with a depth-generic block.

## Interface
- STAGES, 3: in-flight stages tracked behind decode, legal 2..8
- RA_W, 4: register address width
- LOAD_STAGE, 2: first stage whose load result can be forwarded, legal 1..STAGES
- FW (derived), $clog2(STAGES+1): forwarding select width
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  decode holds an instruction
- id_rs1, id_rs2  in  RA_W  source register addresses
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RA_W  destination register
- id_wr  in  1  instruction writes id_rd
- id_load  in  1  result produced at LOAD_STAGE, not stage 1
- id_halt  in  1  halt instruction
- flush  in  1  discard the instruction in decode
- id_ready  out  1  decode instruction is accepted (issued or discarded) this cycle
- stall  out  1  id_valid & ~id_ready
- fwd1_sel, fwd2_sel  out  FW  0 = register file, k = forward from stage k
- stage_valid  out  STAGES  bit k-1 = stage k holds an instruction
- halt_sys  out  1  sticky: halt instruction has retired
- stall_cnt  out  16  saturating count of hazard stall cycles

## Operation
- Per-stage record: valid, rd, wr, load, halt. Stage 1 youngest, stage STAGES oldest.
- Shift every edge unless halt_sys=1: stage k+1 <= stage k; stage 1 <= decode record if id_valid & id_ready & ~flush, else bubble (valid=0). Stall never freezes stages 2..STAGES; it inserts bubbles.
- Source match for source s: s_used and stage k valid & wr & rd==s. Youngest (smallest k) match wins.
- Match available iff ~load or k >= LOAD_STAGE. Available -> fwd_sel=k. Unavailable -> hazard stall. No match -> fwd_sel=0.
- fwd selects are computed regardless of id_valid; consumers qualify with id_valid.
- halt_pending = halt_sys | any stage valid with halt.
- id_ready = flush | (~halt_pending & ~hazard). Flush beats hazard and halt; instruction is dropped.
- halt_sys set on the edge a valid halt record leaves stage STAGES; holds until rst. With halt_sys=1, all stage valids are 0 and no issue occurs.
- stall_cnt increments when id_valid & ~id_ready & ~halt_pending & ~flush; saturates at 16'hFFFF.
- Address 0 is tracked like any other register.

## Timing
- Reset (async, immediate): all stage_valid=0, halt_sys=0, stall_cnt=0. Hence id_ready=1, stall=0, fwd selects 0.
- id_ready, stall and fwd selects are combinational from the stage registers and decode inputs, with no input-to-state loop.
- An instruction issued at edge E0 occupies stage k after edge E(k-1) and leaves at edge E(STAGES).
- Load-use with LOAD_STAGE=L: a consumer immediately behind the load stalls L-1 cycles, then forwards from stage L.
- A halt issued at E0 drops id_ready from the next cycle; halt_sys=1 after E(STAGES). In-flight older instructions drain normally.
- rst asserted mid-operation discards all records, including a pending halt; issue resumes on the first edge after deassertion.

## Test plan
- STAGES=3, LOAD_STAGE=2. Fill pipeline, pulse rst mid-cycle -> stage_valid=3'b000, halt_sys=0, stall_cnt=0 before the next edge.
- ALU chain: issue rd=3 wr, next cycle rs1=3 -> fwd1_sel=1, id_ready=1. Bubble, then rs2=3 two cycles after the producer -> fwd2_sel=2. Four cycles after -> fwd sel 0.
- Load-use: issue load rd=5, next cycle rs1=5 -> id_ready=0 for 1 cycle, stall_cnt=1. Following cycle fwd1_sel=2, id_ready=1.
- Youngest wins: stage 1 and stage 2 both valid, wr, rd=4; rs1=4 -> fwd1_sel=1.
- Halt: issue halt at E0 -> id_ready=0 after E0 with id_valid=1. halt_sys=1 after E3. stall_cnt unchanged. halt_sys stays 1 for 10+ cycles.
- Flush during load-use stall -> id_ready=1, stage 1 bubble on the next edge, stall_cnt unchanged. Also verify stall_cnt holds 16'hFFFF under continued stalls.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Depth-generic hazard, forwarding and halt control.
// Tracks in-flight destination records behind decode.
module pipe_hazard_ctrl #(
  parameter int STAGES = 3,
  parameter int RA_W = 4,
  parameter int LOAD_STAGE = 2,
  localparam int FW = $clog2(STAGES + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_rs1_used,
  input  logic            id_rs2_used,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_wr,
  input  logic            id_load,
  input  logic            id_halt,
  input  logic            flush,
  output logic            id_ready,
  output logic            stall,
  output logic [FW-1:0]   fwd1_sel,
  output logic [FW-1:0]   fwd2_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic            halt_sys,
  output logic [15:0]     stall_cnt
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] wr_q;
  logic [STAGES-1:0] ld_q;
  logic [STAGES-1:0] hl_q;
  logic [RA_W-1:0]   rd_q [STAGES];

  logic haz1;
  logic haz2;
  logic hazard;
  logic halt_pending;
  logic issue;
  logic halt_exit;
  logic cnt_inc;

  // Oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd1_sel = '0;
    haz1 = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (id_rs1_used && v_q[k-1] && wr_q[k-1] &&
          rd_q[k-1] == id_rs1) begin
        if (!ld_q[k-1] || k >= LOAD_STAGE) begin
          fwd1_sel = FW'(k);
          haz1 = 1'b0;
        end else begin
          fwd1_sel = '0;
          haz1 = 1'b1;
        end
      end
    end
  end

  always_comb begin
    fwd2_sel = '0;
    haz2 = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (id_rs2_used && v_q[k-1] && wr_q[k-1] &&
          rd_q[k-1] == id_rs2) begin
        if (!ld_q[k-1] || k >= LOAD_STAGE) begin
          fwd2_sel = FW'(k);
          haz2 = 1'b0;
        end else begin
          fwd2_sel = '0;
          haz2 = 1'b1;
        end
      end
    end
  end

  assign hazard = haz1 | haz2;
  assign halt_pending = halt_sys | (|(v_q & hl_q));
  assign id_ready = flush | (~halt_pending & ~hazard);
  assign stall = id_valid & ~id_ready;
  assign issue = id_valid & id_ready & ~flush;
  assign halt_exit = v_q[STAGES-1] & hl_q[STAGES-1];
  assign cnt_inc = id_valid & ~id_ready &
                   ~halt_pending & ~flush;
  assign stage_valid = v_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      wr_q <= '0;
      ld_q <= '0;
      hl_q <= '0;
      for (int k = 0; k < STAGES; k++) rd_q[k] <= '0;
      halt_sys <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!halt_sys) begin
        // A retiring halt leaves nothing behind it in flight.
        if (halt_exit) begin
          v_q <= '0;
          halt_sys <= 1'b1;
        end else begin
          v_q <= {v_q[STAGES-2:0], issue};
        end
        wr_q <= {wr_q[STAGES-2:0], id_wr};
        ld_q <= {ld_q[STAGES-2:0], id_load};
        hl_q <= {hl_q[STAGES-2:0], id_halt};
        for (int k = STAGES - 1; k >= 1; k--)
          rd_q[k] <= rd_q[k-1];
        rd_q[0] <= id_rd;
      end
      if (cnt_inc && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl.
// Second instance runs a free load-use loop to saturate stall_cnt.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [3:0] id_rs1;
  logic [3:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic [3:0] id_rd;
  logic       id_wr;
  logic       id_load;
  logic       id_halt;
  logic       flush;
  logic       id_ready;
  logic       stall;
  logic [1:0] fwd1_sel;
  logic [1:0] fwd2_sel;
  logic [2:0] stage_valid;
  logic       halt_sys;
  logic [15:0] stall_cnt;

  logic       s_rst;
  logic       s_ready;
  logic       s_stall;
  logic [3:0] s_fwd1;
  logic [3:0] s_fwd2;
  logic [7:0] s_sv;
  logic       s_halt;
  logic [15:0] s_cnt;

  int checks;
  int errors;
  int cyc;

  pipe_hazard_ctrl #(
    .STAGES(3), .RA_W(4), .LOAD_STAGE(2)
  ) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .id_halt(id_halt),
    .flush(flush),
    .id_ready(id_ready), .stall(stall),
    .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .stage_valid(stage_valid),
    .halt_sys(halt_sys),
    .stall_cnt(stall_cnt)
  );

  // Self-dependent load: 7 stall cycles in every 8.
  pipe_hazard_ctrl #(
    .STAGES(8), .RA_W(4), .LOAD_STAGE(8)
  ) sat (
    .clk(clk), .rst(s_rst),
    .id_valid(1'b1),
    .id_rs1(4'd5), .id_rs2(4'd0),
    .id_rs1_used(1'b1),
    .id_rs2_used(1'b0),
    .id_rd(4'd5), .id_wr(1'b1),
    .id_load(1'b1), .id_halt(1'b0),
    .flush(1'b0),
    .id_ready(s_ready), .stall(s_stall),
    .fwd1_sel(s_fwd1), .fwd2_sel(s_fwd2),
    .stage_valid(s_sv),
    .halt_sys(s_halt),
    .stall_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic clr_in();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0;
    id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_wr = 0; id_load = 0;
    id_halt = 0; flush = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drain();
    clr_in();
    repeat (3) step();
  endtask

  task automatic test_reset();
    clr_in();
    rst = 1;
    #12;
    checks++;
    if (stage_valid !== 3'b000) begin
      errors++;
      $display("FAIL rst_sv got %b exp 000", stage_valid);
    end
    checks++;
    if (halt_sys !== 1'b0 || stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_state got h=%b c=%0d exp 0 0",
               halt_sys, stall_cnt);
    end
    checks++;
    if (id_ready !== 1'b1 || stall !== 1'b0 ||
        fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_out got r=%b s=%b f=%0d/%0d exp 1 0 0/0",
               id_ready, stall, fwd1_sel, fwd2_sel);
    end
    rst = 0;
    step();
  endtask

  task automatic test_alu_chain();
    drain();
    id_valid = 1; id_rd = 3; id_wr = 1;
    step();
    clr_in();
    id_valid = 1; id_rs1 = 3; id_rs1_used = 1;
    settle();
    checks++;
    if (fwd1_sel !== 2'd1 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_fwd1 got sel=%0d r=%b exp 1 1",
               fwd1_sel, id_ready);
    end
    step();
    clr_in();
    id_valid = 1; id_rs2 = 3; id_rs2_used = 1;
    settle();
    checks++;
    if (fwd2_sel !== 2'd2 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL alu_fwd2 got sel=%0d r=%b exp 2 1",
               fwd2_sel, id_ready);
    end
    step();
    clr_in();
    id_rs1 = 3; id_rs1_used = 1;
    settle();
    checks++;
    if (fwd1_sel !== 2'd3) begin
      errors++;
      $display("FAIL alu_fwd3 got %0d exp 3", fwd1_sel);
    end
    step();
    id_rs2 = 3; id_rs2_used = 1;
    settle();
    checks++;
    if (fwd1_sel !== 2'd0 || fwd2_sel !== 2'd0) begin
      errors++;
      $display("FAIL alu_gone got %0d/%0d exp 0/0",
               fwd1_sel, fwd2_sel);
    end
  endtask

  task automatic test_load_use();
    drain();
    id_valid = 1; id_rd = 5; id_wr = 1; id_load = 1;
    step();
    clr_in();
    id_valid = 1; id_rs1 = 5; id_rs1_used = 1;
    settle();
    checks++;
    if (id_ready !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got r=%b s=%b exp 0 1",
               id_ready, stall);
    end
    step();
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL lu_cnt got %0d exp 1", stall_cnt);
    end
    checks++;
    if (fwd1_sel !== 2'd2 || id_ready !== 1'b1) begin
      errors++;
      $display("FAIL lu_fwd got sel=%0d r=%b exp 2 1",
               fwd1_sel, id_ready);
    end
    step();
  endtask

  task automatic test_youngest();
    drain();
    id_valid = 1; id_rd = 4; id_wr = 1;
    step();
    step();
    clr_in();
    id_valid = 1;
    id_rs1 = 4; id_rs1_used = 1;
    id_rs2 = 4; id_rs2_used = 1;
    settle();
    checks++;
    if (fwd1_sel !== 2'd1 || fwd2_sel !== 2'd1) begin
      errors++;
      $display("FAIL young got %0d/%0d exp 1/1",
               fwd1_sel, fwd2_sel);
    end
    step();
  endtask

  task automatic test_flush();
    drain();
    id_valid = 1; id_rd = 6; id_wr = 1; id_load = 1;
    step();
    clr_in();
    id_valid = 1; id_rs2 = 6; id_rs2_used = 1;
    flush = 1;
    settle();
    checks++;
    if (id_ready !== 1'b1 || stall !== 1'b0) begin
      errors++;
      $display("FAIL fl_ready got r=%b s=%b exp 1 0",
               id_ready, stall);
    end
    step();
    clr_in();
    checks++;
    if (stage_valid !== 3'b010) begin
      errors++;
      $display("FAIL fl_bubble got %b exp 010", stage_valid);
    end
    checks++;
    if (stall_cnt !== 16'd1) begin
      errors++;
      $display("FAIL fl_cnt got %0d exp 1", stall_cnt);
    end
  endtask

  task automatic test_mid_reset();
    drain();
    for (int i = 1; i <= 3; i++) begin
      id_valid = 1; id_rd = 4'(i); id_wr = 1;
      step();
    end
    clr_in();
    checks++;
    if (stage_valid !== 3'b111) begin
      errors++;
      $display("FAIL mr_fill got %b exp 111", stage_valid);
    end
    #1 rst = 1;
    #1;
    checks++;
    if (stage_valid !== 3'b000 || halt_sys !== 1'b0 ||
        stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mr_clear got sv=%b h=%b c=%0d exp 000 0 0",
               stage_valid, halt_sys, stall_cnt);
    end
    rst = 0;
    id_valid = 1; id_rd = 7; id_wr = 1;
    step();
    clr_in();
    checks++;
    if (stage_valid !== 3'b001) begin
      errors++;
      $display("FAIL mr_resume got %b exp 001", stage_valid);
    end
  endtask

  task automatic test_halt();
    drain();
    id_valid = 1; id_halt = 1;
    settle();
    checks++;
    if (id_ready !== 1'b1) begin
      errors++;
      $display("FAIL h_issue got %b exp 1", id_ready);
    end
    step();
    clr_in();
    id_valid = 1; id_rd = 2; id_wr = 1;
    settle();
    checks++;
    if (id_ready !== 1'b0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL h_block got r=%b s=%b exp 0 1",
               id_ready, stall);
    end
    step();
    step();
    checks++;
    if (halt_sys !== 1'b0 || stage_valid !== 3'b100) begin
      errors++;
      $display("FAIL h_e2 got h=%b sv=%b exp 0 100",
               halt_sys, stage_valid);
    end
    step();
    checks++;
    if (halt_sys !== 1'b1 || stage_valid !== 3'b000) begin
      errors++;
      $display("FAIL h_e3 got h=%b sv=%b exp 1 000",
               halt_sys, stage_valid);
    end
    repeat (12) step();
    checks++;
    if (halt_sys !== 1'b1 || id_ready !== 1'b0 ||
        stage_valid !== 3'b000) begin
      errors++;
      $display("FAIL h_hold got h=%b r=%b sv=%b exp 1 0 000",
               halt_sys, id_ready, stage_valid);
    end
    checks++;
    if (stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL h_cnt got %0d exp 0", stall_cnt);
    end
  endtask

  task automatic test_saturation();
    while (cyc < 75200) @(posedge clk);
    #1;
    checks++;
    if (s_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_reach got %h exp ffff", s_cnt);
    end
    repeat (24) step();
    checks++;
    if (s_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_hold got %h exp ffff", s_cnt);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    s_rst = 1;
    #12 s_rst = 0;
  end

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_youngest();
    test_flush();
    test_mid_reset();
    test_halt();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
